// File: rtl/rv_mul_engine.sv
// Byte-serial XLEN x XLEN -> low-XLEN multiplier for the MUL path: one 8x8 partial product per cycle.
// Optional build macro MUL_ZERO_SKIP_EN: zero operands complete in one cycle without entering CALC.
module rv_mul_engine #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int NBYTES = XLEN / 8;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [XLEN-1:0] a_r, b_r, acc_r, result_r, acc_sum_s;
  logic [IW-1:0]   i_r, j_r;
  logic            busy_r, done_r, busy_s, done_s;
  logic            accept_s, last_s, j_wrap_s, zero_s;

  // Unsigned 8x8 product placed at byte offset i+j, truncated to XLEN bits
  function automatic logic [XLEN-1:0] pp_term(input logic [7:0] a_byte, input logic [7:0] b_byte,
                                              input logic [IW-1:0] i, input logic [IW-1:0] j);
    logic [XLEN+15:0] wide;
    wide       = '0;
    wide[15:0] = a_byte * b_byte;
    wide       = wide << ((32'(i) + 32'(j)) * 32'd8);
    return wide[XLEN-1:0];
  endfunction

  assign accept_s  = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign last_s    = (state_r == S_CALC) && (i_r == IW'(NBYTES - 1));
  assign j_wrap_s  = (32'(i_r) + 32'(j_r) + 32'd1) >= NBYTES;
  assign acc_sum_s = acc_r + pp_term(a_r[{i_r, 3'b000} +: 8], b_r[{j_r, 3'b000} +: 8], i_r, j_r);

`ifdef MUL_ZERO_SKIP_EN
  assign zero_s = (opa == '0) || (opb == '0);
`else
  assign zero_s = 1'b0;
`endif

  // State register plus registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_s = zero_s ? S_DONE : S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) begin
          state_s = S_DONE;
        end else begin
          state_s = S_CALC;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Flags follow the state being entered so they line up with it after the edge
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      S_CALC:  busy_s = 1'b1;
      S_DONE:  done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Operand capture, byte-pair sequencing, accumulation and result latch
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      i_r      <= '0;
      j_r      <= '0;
      result_r <= '0;
    end else if (accept_s) begin
      a_r   <= opa;
      b_r   <= opb;
      acc_r <= '0;
      i_r   <= '0;
      j_r   <= '0;
      if (zero_s) begin
        result_r <= '0;
      end
    end else if (state_r == S_CALC) begin
      acc_r <= acc_sum_s;
      if (j_wrap_s) begin
        i_r <= i_r + 1'b1;
        j_r <= '0;
      end else begin
        j_r <= j_r + 1'b1;
      end
      if (last_s) begin
        result_r <= acc_sum_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_rv_mul_engine.sv
// Scoreboard bench for rv_mul_engine: driver queues expected result and done cycle, monitor checks on done.
module tb_rv_mul_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];
  int          cyc_q[$];

`ifdef MUL_ZERO_SKIP_EN
  localparam int ZLAT  = 0;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT  = 10;
  localparam int ZBUSY = 10;
`endif

  rv_mul_engine #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        check("result", result, exp_q.pop_front());
        check("done_cycle", cyc, cyc_q.pop_front());
      end
    end
  end

  // Call between a negedge and the next posedge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int lat);
    opa   = a;
    opb   = b;
    start = 1'b1;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + 1 + lat);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(output int nbusy);
    bit fin = 1'b0;
    nbusy = 0;
    for (int t = 0; t < 60 && !fin; t++) begin
      @(negedge clk);
      #2;
      if (busy) nbusy++;
      if (exp_q.size() == 0 && !busy) fin = 1'b1;
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  logic [31:0] vec_a[6] = '{32'hFFFF_FFFF, 32'h0102_0304, 32'h0001_0000, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [31:0] vec_b[6] = '{32'hFFFF_FFFF, 32'h0000_0100, 32'h0001_0000, 32'h0000_0010, 32'h0000_0002, 32'h0000_0002};
  logic [31:0] vec_r[6] = '{32'h0000_0001, 32'h0203_0400, 32'h0000_0000, 32'h0001_2340, 32'h0000_0000, 32'hFFFF_FFFE};

  initial begin
    int nb;
    int k;
    int d0;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd3, 32'd5, 32'h0000_000F, 10);
    drain(nb);
    check("busy_cycles_3x5", nb, 32'd10);

    for (int v = 0; v < 6; v++) begin
      issue(vec_a[v], vec_b[v], vec_r[v], 10);
      drain(nb);
    end

    // Start held through CALC and DONE, opa changed after capture
    d0 = done_cnt;
    k  = cyc;
    opa = 32'd7;
    opb = 32'd6;
    start = 1'b1;
    exp_q.push_back(32'h0000_002A);
    cyc_q.push_back(k + 11);
    exp_q.push_back(32'h0000_0036);
    cyc_q.push_back(k + 22);
    @(posedge clk);
    #1 opa = 32'd9;
    repeat (11) @(posedge clk);
    #1 start = 1'b0;
    drain(nb);
    check("hold_done_count", done_cnt - d0, 32'd2);

    // Reset in the middle of CALC aborts without a done pulse
    issue(32'd2, 32'd2, 32'd4, 10);
    drain(nb);
    d0 = done_cnt;
    opa = 32'd5;
    opb = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_result_late", result, 32'd0);

    issue(32'h00FF_00FF, 32'h0000_0101, 32'hFFFF_FFFF, 10);
    drain(nb);

    issue(32'd0, 32'h0000_1234, 32'd0, ZLAT);
    drain(nb);
    check("zero_a_busy", nb, ZBUSY);
    issue(32'h0000_1234, 32'd0, 32'd0, ZLAT);
    drain(nb);
    check("zero_b_busy", nb, ZBUSY);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
